// File: rtl/dp_pkg.sv
// Shared encodings for datapath_pipe: ALU opcodes, write-source select,
// multiplier FSM states and flag bit positions.
package dp_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SHL1  = 3'd5;
    localparam logic [2:0] OP_SHR1  = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    // {write_alu, is_load}; both 00 and 11 select the immediate
    localparam logic [1:0] SRC_IMM0 = 2'b00;
    localparam logic [1:0] SRC_RAM  = 2'b01;
    localparam logic [1:0] SRC_ALU  = 2'b10;
    localparam logic [1:0] SRC_IMM1 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;

endpackage

// File: rtl/datapath_pipe_reg_file.sv
// reg_file_p: register file with two asynchronous read ports, one synchronous
// write port and asynchronous clear to zero.
module reg_file_p #(
    parameter int WIDTH = 8,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [NREGS-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

    assign rdata_a = mem[ra];
    assign rdata_b = mem[rb];

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: operand read + ALU in EX, registered WB that commits to
// the register file next cycle. Define DATAPATH_MUL_EN for the shift-add multiplier.
module datapath_pipe
    import dp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 16,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       alu_opcode,
    input  logic             imm_flag,
    input  logic             write_alu,
    input  logic             is_load,
    input  logic             write_en,
    input  logic             mul_req,
    input  logic [AW-1:0]    write_addr,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    input  logic [WIDTH-1:0] imm_data,
    input  logic [WIDTH-1:0] ram_data,
    output logic [WIDTH-1:0] read_a,
    output logic [WIDTH-1:0] read_b,
    output logic [WIDTH-1:0] alu_out,
    output logic             alu_zero,
    output logic             alu_carry,
    output logic             wb_valid
);

    logic [WIDTH-1:0] rf_a, rf_b;
    logic [WIDTH-1:0] op_b, alu_res, wr_data;
    logic             alu_c;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic [1:0]       flags;
    logic             rf_we;
    logic             issue;

    // Multiplier hand-off into WB (constant in the default build)
    logic             mul_issue, mul_fin, mul_we;
    logic [AW-1:0]    mul_addr;
    logic [WIDTH-1:0] mul_lo, mul_hi;

    assign rf_we = wb_valid && (wb_addr != '0);
    assign issue = valid_in && ready_out;

    reg_file_p #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .ra      (ra_addr),
        .rb      (rb_addr),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    // r0 is hard zero even when WB is holding a (dropped) write to it
    always_comb begin
        read_a = rf_a;
        if (ra_addr == '0)
            read_a = '0;
        else if (wb_valid && wb_addr == ra_addr)
            read_a = wb_data;
    end

    always_comb begin
        read_b = rf_b;
        if (rb_addr == '0)
            read_b = '0;
        else if (wb_valid && wb_addr == rb_addr)
            read_b = wb_data;
    end

    assign op_b = imm_flag ? imm_data : read_b;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (alu_opcode)
            OP_ADD:   {alu_c, alu_res} = {1'b0, read_a} + {1'b0, op_b};
            OP_SUB: begin
                alu_res = read_a - op_b;
                alu_c   = (read_a < op_b);
            end
            OP_AND:   alu_res = read_a & op_b;
            OP_OR:    alu_res = read_a | op_b;
            OP_XOR:   alu_res = read_a ^ op_b;
            OP_SHL1: begin
                alu_res = {read_a[WIDTH-2:0], 1'b0};
                alu_c   = read_a[WIDTH-1];
            end
            OP_SHR1: begin
                alu_res = {1'b0, read_a[WIDTH-1:1]};
                alu_c   = read_a[0];
            end
            OP_PASSB: alu_res = op_b;
            default: ;
        endcase
    end

    always_comb begin
        wr_data = imm_data;
        case ({write_alu, is_load})
            SRC_ALU:  wr_data = alu_res;
            SRC_RAM:  wr_data = ram_data;
            default:  wr_data = imm_data;
        endcase
    end

    // WB stage and flags; a finishing multiply owns WB since no issue can overlap it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            flags    <= '0;
        end else if (mul_fin) begin
            wb_valid <= mul_we;
            if (mul_we) begin
                wb_addr <= mul_addr;
                wb_data <= mul_lo;
            end
            flags[FLAG_ZERO]  <= (mul_lo == '0);
            flags[FLAG_CARRY] <= (mul_hi != '0);
        end else if (issue && !mul_issue) begin
            wb_valid <= write_en;
            if (write_en) begin
                wb_addr <= write_addr;
                wb_data <= wr_data;
            end
            if (write_alu) begin
                flags[FLAG_ZERO]  <= (alu_res == '0);
                flags[FLAG_CARRY] <= alu_c;
            end
        end else begin
            wb_valid <= 1'b0;
        end
    end

    assign alu_out   = wb_data;
    assign alu_zero  = flags[FLAG_ZERO];
    assign alu_carry = flags[FLAG_CARRY];

`ifdef DATAPATH_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mul_state_t         state;
    logic               ready;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign mul_issue = issue && mul_req;

    // Operands and destination are latched at issue so control may move on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b1;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            mul_we   <= 1'b0;
            mul_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_issue) begin
                        state    <= ST_MUL;
                        ready    <= 1'b0;
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, read_a};
                        mplier   <= op_b;
                        cnt      <= '0;
                        mul_we   <= write_en;
                        mul_addr <= write_addr;
                    end
                end
                ST_MUL: begin
                    if (mplier[0])
                        acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_out = ready;
    assign mul_fin   = (state == ST_DONE);
    assign mul_lo    = acc[WIDTH-1:0];
    assign mul_hi    = acc[2*WIDTH-1:WIDTH];
`else
    logic unused_mul;

    assign unused_mul = mul_req;
    assign ready_out  = 1'b1;
    assign mul_issue  = 1'b0;
    assign mul_fin    = 1'b0;
    assign mul_we     = 1'b0;
    assign mul_addr   = '0;
    assign mul_lo     = '0;
    assign mul_hi     = '0;
`endif

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed-vector bench for datapath_pipe; multiplier scenarios run when
// DATAPATH_MUL_EN is defined for both bench and design.
module tb_datapath_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic [2:0] alu_opcode = '0;
    logic       imm_flag = 1'b0, write_alu = 1'b0, is_load = 1'b0, write_en = 1'b0, mul_req = 1'b0;
    logic [3:0] write_addr = '0, ra_addr = '0, rb_addr = '0;
    logic [7:0] imm_data = '0, ram_data = '0;
    logic [7:0] read_a, read_b, alu_out;
    logic       alu_zero, alu_carry, wb_valid;

    int n_checks = 0;
    int n_fail   = 0;

    datapath_pipe #(.WIDTH(8), .NREGS(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .alu_opcode(alu_opcode), .imm_flag(imm_flag), .write_alu(write_alu),
        .is_load(is_load), .write_en(write_en), .mul_req(mul_req),
        .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .imm_data(imm_data), .ram_data(ram_data), .read_a(read_a), .read_b(read_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [2:0] op, input logic imf, wa, ld, we,
                         input logic [3:0] wad, ra, rb, input logic [7:0] imm, ram);
        valid_in = 1'b1; mul_req = 1'b0;
        alu_opcode = op; imm_flag = imm_flag ^ imm_flag | imf;
        write_alu = wa; is_load = ld; write_en = we;
        write_addr = wad; ra_addr = ra; rb_addr = rb; imm_data = imm; ram_data = ram;
    endtask

    task automatic idle();
        valid_in = 1'b0; write_en = 1'b0; mul_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (alu_out !== 8'h00) begin n_fail++; $display("FAIL reset_alu_out got %h exp 00", alu_out); end
        n_checks++; if ({alu_zero, alu_carry, wb_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {alu_zero, alu_carry, wb_valid}); end
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready_out); end
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        drive(3'd0, 1, 0, 0, 1, 4'd1, 4'd0, 4'd0, 8'h7F, 8'h00); tick();
        n_checks++; if (alu_out !== 8'h7F || wb_valid !== 1'b1) begin n_fail++; $display("FAIL imm_write got %h/%b exp 7f/1", alu_out, wb_valid); end
        drive(3'd0, 1, 1, 0, 1, 4'd2, 4'd1, 4'd0, 8'h01, 8'h00); #1;
        n_checks++; if (read_a !== 8'h7F) begin n_fail++; $display("FAIL fwd_read_a got %h exp 7f", read_a); end
        tick();
        n_checks++; if (alu_out !== 8'h80) begin n_fail++; $display("FAIL fwd_add got %h exp 80", alu_out); end
        n_checks++; if ({alu_zero, alu_carry} !== 2'b00) begin n_fail++; $display("FAIL fwd_add_flags got %b exp 00", {alu_zero, alu_carry}); end
        idle(); ra_addr = 4'd1; #1;
        n_checks++; if (read_a !== 8'h7F) begin n_fail++; $display("FAIL rf_r1 got %h exp 7f", read_a); end
    endtask

    task automatic test_sub_r0();
        drive(3'd1, 1, 1, 0, 1, 4'd3, 4'd0, 4'd0, 8'h01, 8'h00); tick();
        n_checks++; if (alu_out !== 8'hFF || {alu_zero, alu_carry} !== 2'b01) begin n_fail++; $display("FAIL sub_borrow got %h z%b c%b exp ff z0 c1", alu_out, alu_zero, alu_carry); end
        drive(3'd7, 1, 1, 0, 1, 4'd0, 4'd0, 4'd0, 8'h33, 8'h00); tick();
        n_checks++; if (alu_out !== 8'h33 || alu_carry !== 1'b0) begin n_fail++; $display("FAIL passb_r0 got %h c%b exp 33 c0", alu_out, alu_carry); end
        idle(); ra_addr = 4'd0; rb_addr = 4'd0; #1;
        n_checks++; if (read_a !== 8'h00 || read_b !== 8'h00) begin n_fail++; $display("FAIL r0_fwd got %h/%h exp 00/00", read_a, read_b); end
        tick();
        n_checks++; if (read_a !== 8'h00) begin n_fail++; $display("FAIL r0_read got %h exp 00", read_a); end
    endtask

    task automatic test_shift();
        drive(3'd0, 1, 0, 0, 1, 4'd5, 4'd0, 4'd0, 8'h81, 8'h00); tick();
        drive(3'd5, 0, 1, 0, 1, 4'd6, 4'd5, 4'd0, 8'h00, 8'h00); tick();
        n_checks++; if (alu_out !== 8'h02 || {alu_zero, alu_carry} !== 2'b01) begin n_fail++; $display("FAIL shl1 got %h z%b c%b exp 02 z0 c1", alu_out, alu_zero, alu_carry); end
        drive(3'd2, 1, 1, 0, 1, 4'd7, 4'd6, 4'd0, 8'h00, 8'h00); tick();
        n_checks++; if (alu_out !== 8'h00 || {alu_zero, alu_carry} !== 2'b10) begin n_fail++; $display("FAIL and_zero got %h z%b c%b exp 00 z1 c0", alu_out, alu_zero, alu_carry); end
        drive(3'd6, 0, 1, 0, 1, 4'd8, 4'd5, 4'd0, 8'h00, 8'h00); tick();
        n_checks++; if (alu_out !== 8'h40 || {alu_zero, alu_carry} !== 2'b01) begin n_fail++; $display("FAIL shr1 got %h z%b c%b exp 40 z0 c1", alu_out, alu_zero, alu_carry); end
    endtask

    task automatic test_load();
        drive(3'd0, 0, 0, 1, 1, 4'd4, 4'd0, 4'd0, 8'h00, 8'h5A); tick();
        n_checks++; if (alu_out !== 8'h5A || alu_carry !== 1'b1) begin n_fail++; $display("FAIL load_hold got %h c%b exp 5a c1", alu_out, alu_carry); end
        idle(); ra_addr = 4'd4; rb_addr = 4'd4; #1;
        n_checks++; if (read_a !== 8'h5A || read_b !== 8'h5A) begin n_fail++; $display("FAIL load_fwd got %h/%h exp 5a/5a", read_a, read_b); end
        drive(3'd2, 1, 1, 1, 1, 4'd14, 4'd0, 4'd0, 8'h3C, 8'h99); tick();
        n_checks++; if (alu_out !== 8'h3C || {alu_zero, alu_carry} !== 2'b10) begin n_fail++; $display("FAIL src11 got %h z%b c%b exp 3c z1 c0", alu_out, alu_zero, alu_carry); end
    endtask

    task automatic test_no_write();
        drive(3'd0, 1, 1, 0, 0, 4'd15, 4'd1, 4'd0, 8'h81, 8'h00); tick();
        n_checks++; if (wb_valid !== 1'b0 || alu_out !== 8'h3C) begin n_fail++; $display("FAIL nowrite_wb got %b/%h exp 0/3c", wb_valid, alu_out); end
        n_checks++; if ({alu_zero, alu_carry} !== 2'b11) begin n_fail++; $display("FAIL add_carry got z%b c%b exp z1 c1", alu_zero, alu_carry); end
        idle(); ra_addr = 4'd15; tick();
        n_checks++; if (read_a !== 8'h00) begin n_fail++; $display("FAIL nowrite_rf got %h exp 00", read_a); end
    endtask

    task automatic test_back_to_back();
        drive(3'd0, 1, 0, 0, 1, 4'd9, 4'd0, 4'd0, 8'h11, 8'h00); tick();
        drive(3'd0, 1, 1, 0, 1, 4'd9, 4'd9, 4'd0, 8'h01, 8'h00); tick();
        n_checks++; if (alu_out !== 8'h12) begin n_fail++; $display("FAIL b2b_1 got %h exp 12", alu_out); end
        tick();
        n_checks++; if (alu_out !== 8'h13) begin n_fail++; $display("FAIL b2b_2 got %h exp 13", alu_out); end
        idle(); tick();
        n_checks++; if (read_a !== 8'h13) begin n_fail++; $display("FAIL b2b_rf got %h exp 13", read_a); end
    endtask

`ifdef DATAPATH_MUL_EN
    task automatic test_mul();
        int  low = 0;
        bit  wb_seen = 1'b0;
        drive(3'd0, 1, 0, 0, 1, 4'd10, 4'd0, 4'd0, 8'h10, 8'h00); tick();
        drive(3'd0, 1, 1, 0, 1, 4'd11, 4'd10, 4'd0, 8'h11, 8'h00); mul_req = 1'b1; tick();
        drive(3'd0, 1, 0, 0, 1, 4'd12, 4'd0, 4'd0, 8'h77, 8'h00);
        while (ready_out === 1'b0 && low < 20) begin
            if (wb_valid !== 1'b0) wb_seen = 1'b1;
            low++; tick();
        end
        idle();
        n_checks++; if (low != 9) begin n_fail++; $display("FAIL mul_stall got %0d cycles exp 9", low); end
        n_checks++; if (wb_seen) begin n_fail++; $display("FAIL mul_held got wb_valid 1 exp 0 while busy"); end
        n_checks++; if (alu_out !== 8'h10 || {alu_zero, alu_carry} !== 2'b01 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL mul_result got %h z%b c%b v%b exp 10 z0 c1 v1", alu_out, alu_zero, alu_carry, wb_valid); end
        tick(); ra_addr = 4'd11; rb_addr = 4'd12; #1;
        n_checks++; if (read_a !== 8'h10 || read_b !== 8'h00) begin n_fail++; $display("FAIL mul_rf got %h/%h exp 10/00", read_a, read_b); end
    endtask

    task automatic test_mul_reset();
        drive(3'd0, 1, 1, 0, 1, 4'd13, 4'd10, 4'd0, 8'h03, 8'h00); mul_req = 1'b1; tick();
        idle(); tick(); tick();
        rst = 1'b1; #1;
        n_checks++; if (alu_out !== 8'h00 || {alu_zero, alu_carry, wb_valid} !== 3'b000 || ready_out !== 1'b1) begin n_fail++; $display("FAIL mul_abort got %h %b r%b exp 00 000 r1", alu_out, {alu_zero, alu_carry, wb_valid}, ready_out); end
        @(negedge clk); rst = 1'b0;
        tick(); tick(); tick(); ra_addr = 4'd13; #1;
        n_checks++; if (read_a !== 8'h00 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL mul_abort_rf got %h v%b exp 00 v0", read_a, wb_valid); end
    endtask
`else
    task automatic test_mul_ignored();
        drive(3'd0, 1, 1, 0, 1, 4'd10, 4'd0, 4'd0, 8'h22, 8'h00); mul_req = 1'b1; #1;
        n_checks++; if (ready_out !== 1'b1) begin n_fail++; $display("FAIL mul_off_ready got %b exp 1", ready_out); end
        tick();
        n_checks++; if (alu_out !== 8'h22 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL mul_off_alu got %h/%b exp 22/1", alu_out, wb_valid); end
        idle();
    endtask
`endif

    task automatic test_reset_clears();
        idle(); rst = 1'b1; #1;
        n_checks++; if (alu_out !== 8'h00 || {alu_zero, alu_carry, wb_valid} !== 3'b000) begin n_fail++; $display("FAIL rerst_out got %h %b exp 00 000", alu_out, {alu_zero, alu_carry, wb_valid}); end
        @(negedge clk); rst = 1'b0;
        ra_addr = 4'd9; rb_addr = 4'd4; #1;
        n_checks++; if (read_a !== 8'h00 || read_b !== 8'h00) begin n_fail++; $display("FAIL rerst_rf got %h/%h exp 00/00", read_a, read_b); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_sub_r0();
        test_shift();
        test_load();
        test_no_write();
        test_back_to_back();
`ifdef DATAPATH_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_ignored();
`endif
        test_reset_clears();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
